// File: rtl/interface_pkg.sv
// -----------------------------------------------------------------------------
// interface_pkg
// Shared AHB encodings and refill-controller types.
//   TRANS_TYPES   : AHB HTRANS encoding (IDLE, BUSY, NONSEQ, SEQ)
//   HBURST_TYPES  : AHB HBURST encoding used by the refill controller
//   REFILL_STATE  : refill controller FSM states
//   line_burst()  : picks the HBURST code for a given line size and burst mode
// -----------------------------------------------------------------------------
package interface_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } TRANS_TYPES;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5
    } HBURST_TYPES;

    typedef enum logic [1:0] {
        REFILL_IDLE  = 2'd0,
        REFILL_ADDR  = 2'd1,
        REFILL_BURST = 2'd2,
        REFILL_DRAIN = 2'd3
    } REFILL_STATE;

    // Fixed-length burst code: wrapping bursts for critical-word-first,
    // incrementing bursts otherwise. Only 4- and 8-word lines are legal.
    function automatic logic [2:0] line_burst(input int line_words, input logic wrap_en);
        logic [2:0] code;
        if (line_words == 8) begin
            code = wrap_en ? HBURST_WRAP8 : HBURST_INCR8;
        end else begin
            code = wrap_en ? HBURST_WRAP4 : HBURST_INCR4;
        end
        return code;
    endfunction

endpackage

// File: rtl/refill_addr_gen.sv
// -----------------------------------------------------------------------------
// refill_addr_gen
// Beat address and word-index generation for one cache-line refill.
// Holds the latched line base, the running address-phase word index and the
// running data-phase word index; the wrap to the line boundary comes for free
// from the index width (LINE_WORDS is a power of two).
// Ports:
//   clk, rstn   : clock, asynchronous active-low reset
//   load        : latch miss_addr / start_idx and restart both beat counters
//   miss_addr   : missing word address (bits [1:0] ignored)
//   start_idx   : word index of the first beat of the burst
//   addr_adv    : an address phase was accepted this cycle
//   data_adv    : a data beat was captured this cycle
//   beat_addr   : address of the current address phase (drives haddr)
//   addr_last   : current address phase is the last of the line
//   data_idx    : word index of the current data phase
//   data_last   : current data phase is the last of the line
//   data_crit   : current data phase carries the missed word
// -----------------------------------------------------------------------------
module refill_addr_gen
    import interface_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    localparam int IDXW       = $clog2(LINE_WORDS)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load,
    input  logic [31:0]     miss_addr,
    input  logic [IDXW-1:0] start_idx,
    input  logic            addr_adv,
    input  logic            data_adv,
    output logic [31:0]     beat_addr,
    output logic            addr_last,
    output logic [IDXW-1:0] data_idx,
    output logic            data_last,
    output logic            data_crit
);

    logic [31:IDXW+2] line_base_r;
    logic [IDXW-1:0]  crit_idx_r;
    logic [IDXW-1:0]  addr_idx_r;
    logic [IDXW-1:0]  addr_cnt_r;
    logic [IDXW-1:0]  data_idx_r;
    logic [IDXW-1:0]  data_cnt_r;
    logic [IDXW-1:0]  addr_idx_nxt_s;
    logic [IDXW-1:0]  data_idx_nxt_s;
    logic [1:0]       unused_byte_bits_s;

    assign unused_byte_bits_s = miss_addr[1:0];

    // Modulo-LINE_WORDS increment: the carry out of the index simply drops.
    always_comb begin
        addr_idx_nxt_s = addr_idx_r + {{(IDXW-1){1'b0}}, 1'b1};
        data_idx_nxt_s = data_idx_r + {{(IDXW-1){1'b0}}, 1'b1};
    end

    // Beat counters; the address side parks on the last beat so haddr stays put in DRAIN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            line_base_r <= '0;
            crit_idx_r  <= {IDXW{1'b0}};
            addr_idx_r  <= {IDXW{1'b0}};
            addr_cnt_r  <= {IDXW{1'b0}};
            data_idx_r  <= {IDXW{1'b0}};
            data_cnt_r  <= {IDXW{1'b0}};
        end else if (load) begin
            line_base_r <= miss_addr[31:IDXW+2];
            crit_idx_r  <= miss_addr[IDXW+1:2];
            addr_idx_r  <= start_idx;
            addr_cnt_r  <= {IDXW{1'b0}};
            data_idx_r  <= start_idx;
            data_cnt_r  <= {IDXW{1'b0}};
        end else begin
            if (addr_adv && !addr_last) begin
                addr_idx_r <= addr_idx_nxt_s;
                addr_cnt_r <= addr_cnt_r + {{(IDXW-1){1'b0}}, 1'b1};
            end
            if (data_adv) begin
                data_idx_r <= data_idx_nxt_s;
                data_cnt_r <= data_cnt_r + {{(IDXW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign beat_addr = {line_base_r, addr_idx_r, 2'b00};
    assign addr_last = (addr_cnt_r == IDXW'(LINE_WORDS - 1));
    assign data_idx  = data_idx_r;
    assign data_last = (data_cnt_r == IDXW'(LINE_WORDS - 1));
    assign data_crit = (data_idx_r == crit_idx_r);

endmodule

// File: rtl/ahb_refill_ctrl.sv
// -----------------------------------------------------------------------------
// ahb_refill_ctrl
// I-cache line refill master on AHB. One miss produces one fixed-length read
// burst of LINE_WORDS words; each captured word is presented on the fill port
// with its word index.
// Build option: CRITICAL_WORD_FIRST_EN
//   defined   -> wrapping burst (WRAP4/WRAP8) starting at the missed word
//   undefined -> incrementing burst (INCR4/INCR8) starting at word 0
// Ports:
//   clk, rstn             : clock, asynchronous active-low reset
//   miss_req, miss_addr   : miss request (sampled only when idle) and address
//   miss_busy             : refill in progress
//   haddr/htrans/hwrite/hsize/hburst : AHB address-phase outputs
//   hready, hrdata        : AHB ready and read data
//   fill_valid/fill_idx/fill_data    : one strobe per captured word
//   fill_crit, fill_done  : strobe carries the missed word / last word
// -----------------------------------------------------------------------------
module ahb_refill_ctrl
    import interface_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    localparam int IDXW       = $clog2(LINE_WORDS)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            miss_req,
    input  logic [31:0]     miss_addr,
    output logic            miss_busy,
    output logic [31:0]     haddr,
    output logic [1:0]      htrans,
    output logic            hwrite,
    output logic [2:0]      hsize,
    output logic [2:0]      hburst,
    input  logic            hready,
    input  logic [31:0]     hrdata,
    output logic            fill_valid,
    output logic [IDXW-1:0] fill_idx,
    output logic [31:0]     fill_data,
    output logic            fill_crit,
    output logic            fill_done
);

    localparam logic [1:0] S_IDLE  = REFILL_IDLE;
    localparam logic [1:0] S_ADDR  = REFILL_ADDR;
    localparam logic [1:0] S_BURST = REFILL_BURST;
    localparam logic [1:0] S_DRAIN = REFILL_DRAIN;

`ifdef CRITICAL_WORD_FIRST_EN
    localparam logic WRAP_EN = 1'b1;
    logic [IDXW-1:0] start_idx_s;
    assign start_idx_s = miss_addr[IDXW+1:2];
`else
    localparam logic WRAP_EN = 1'b0;
    logic [IDXW-1:0] start_idx_s;
    assign start_idx_s = {IDXW{1'b0}};
`endif

    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;
    logic [1:0]      htrans_r;
    logic [1:0]      trans_nxt_s;
    logic [2:0]      hburst_r;
    logic            miss_busy_r;
    logic            dph_r;
    logic            load_s;
    logic            addr_adv_s;
    logic            capture_s;
    logic [31:0]     beat_addr_s;
    logic            addr_last_s;
    logic [IDXW-1:0] data_idx_s;
    logic            data_last_s;
    logic            data_crit_s;
    // Capture stage: hrdata sampled at the end of a completed data phase.
    logic            cap_valid_r;
    logic [IDXW-1:0] cap_idx_r;
    logic [31:0]     cap_data_r;
    logic            cap_crit_r;
    logic            cap_last_r;
    // Fill stage: presented to the cache one cycle after capture.
    logic            fill_valid_r;
    logic [IDXW-1:0] fill_idx_r;
    logic [31:0]     fill_data_r;
    logic            fill_crit_r;
    logic            fill_done_r;

    assign load_s     = (state_r == S_IDLE) && miss_req;
    assign addr_adv_s = ((state_r == S_ADDR) || (state_r == S_BURST)) && hready;
    // A data phase completes on the same hready that completes the overlapping address phase.
    assign capture_s  = dph_r && hready;

    refill_addr_gen #(
        .LINE_WORDS (LINE_WORDS)
    ) u_addr_gen (
        .clk        (clk),
        .rstn       (rstn),
        .load       (load_s),
        .miss_addr  (miss_addr),
        .start_idx  (start_idx_s),
        .addr_adv   (addr_adv_s),
        .data_adv   (capture_s),
        .beat_addr  (beat_addr_s),
        .addr_last  (addr_last_s),
        .data_idx   (data_idx_s),
        .data_last  (data_last_s),
        .data_crit  (data_crit_s)
    );

    // Next-state logic; DRAIN holds until the last word leaves the capture stage.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (miss_req) state_nxt_s = S_ADDR;
                else          state_nxt_s = S_IDLE;
            end
            S_ADDR: begin
                if (hready) state_nxt_s = S_BURST;
                else        state_nxt_s = S_ADDR;
            end
            S_BURST: begin
                if (hready && addr_last_s) state_nxt_s = S_DRAIN;
                else                       state_nxt_s = S_BURST;
            end
            S_DRAIN: begin
                if (cap_valid_r && cap_last_r) state_nxt_s = S_IDLE;
                else                           state_nxt_s = S_DRAIN;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // HTRANS follows the state being entered so it can be registered.
    always_comb begin
        trans_nxt_s = TRANS_IDLE;
        case (state_nxt_s)
            S_ADDR:  trans_nxt_s = TRANS_NONSEQ;
            S_BURST: trans_nxt_s = TRANS_SEQ;
            default: trans_nxt_s = TRANS_IDLE;
        endcase
    end

    // FSM, bus control registers and the pending-data-phase flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= S_IDLE;
            htrans_r    <= TRANS_IDLE;
            hburst_r    <= HBURST_SINGLE;
            miss_busy_r <= 1'b0;
            dph_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            htrans_r    <= trans_nxt_s;
            miss_busy_r <= (state_nxt_s != S_IDLE);
            if (load_s) begin
                hburst_r <= line_burst(LINE_WORDS, WRAP_EN);
            end
            if (hready) begin
                dph_r <= addr_adv_s;
            end
        end
    end

    // Capture stage: registers hrdata with its index and flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_valid_r <= 1'b0;
            cap_idx_r   <= {IDXW{1'b0}};
            cap_data_r  <= 32'h0000_0000;
            cap_crit_r  <= 1'b0;
            cap_last_r  <= 1'b0;
        end else begin
            cap_valid_r <= capture_s;
            cap_crit_r  <= capture_s && data_crit_s;
            cap_last_r  <= capture_s && data_last_s;
            if (capture_s) begin
                cap_idx_r  <= data_idx_s;
                cap_data_r <= hrdata;
            end
        end
    end

    // Fill stage: one-cycle strobe per word towards the cache.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fill_valid_r <= 1'b0;
            fill_idx_r   <= {IDXW{1'b0}};
            fill_data_r  <= 32'h0000_0000;
            fill_crit_r  <= 1'b0;
            fill_done_r  <= 1'b0;
        end else begin
            fill_valid_r <= cap_valid_r;
            fill_crit_r  <= cap_valid_r && cap_crit_r;
            fill_done_r  <= cap_valid_r && cap_last_r;
            if (cap_valid_r) begin
                fill_idx_r  <= cap_idx_r;
                fill_data_r <= cap_data_r;
            end
        end
    end

    assign miss_busy  = miss_busy_r;
    assign haddr      = beat_addr_s;
    assign htrans     = htrans_r;
    assign hburst     = hburst_r;
    assign hwrite     = 1'b0;
    assign hsize      = 3'b010;
    assign fill_valid = fill_valid_r;
    assign fill_idx   = fill_idx_r;
    assign fill_data  = fill_data_r;
    assign fill_crit  = fill_crit_r;
    assign fill_done  = fill_done_r;

endmodule

// File: tb/tb_ahb_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ahb_refill_ctrl
// Scoreboard bench for ahb_refill_ctrl. Issuing a miss pushes the expected
// address phases and fill strobes of that line (computed from the line
// arithmetic) into queues; a monitor on the falling edge pops and compares.
// A small AHB slave answers reads with a fixed address-hash pattern.
// Honours CRITICAL_WORD_FIRST_EN for the expected burst order.
// -----------------------------------------------------------------------------
module tb_ahb_refill_ctrl;

    localparam int LW   = 4;
    localparam int IDXW = $clog2(LW);
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit         CWF       = 1'b1;
    localparam logic [2:0] EXP_BURST = (LW == 8) ? 3'b100 : 3'b010;
`else
    localparam bit         CWF       = 1'b0;
    localparam logic [2:0] EXP_BURST = (LW == 8) ? 3'b101 : 3'b011;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
    } addr_t;

    typedef struct packed {
        logic [IDXW-1:0] idx;
        logic [31:0]     data;
        logic            crit;
        logic            done;
    } fill_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            miss_req;
    logic [31:0]     miss_addr;
    logic            miss_busy;
    logic [31:0]     haddr;
    logic [1:0]      htrans;
    logic            hwrite;
    logic [2:0]      hsize;
    logic [2:0]      hburst;
    logic            hready;
    logic [31:0]     hrdata;
    logic            fill_valid;
    logic [IDXW-1:0] fill_idx;
    logic [31:0]     fill_data;
    logic            fill_crit;
    logic            fill_done;

    int      vectors    = 0;
    int      miscompares = 0;
    longint  cyc        = 0;
    int      hmode      = 0;   // 0: always ready, 1: 15 ns low / 35 ns high, 2: random
    time     tog_base   = 0;
    addr_t   exp_addr[$];
    fill_t   exp_fill[$];

    ahb_refill_ctrl #(.LINE_WORDS(LW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .miss_req   (miss_req),
        .miss_addr  (miss_addr),
        .miss_busy  (miss_busy),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsize      (hsize),
        .hburst     (hburst),
        .hready     (hready),
        .hrdata     (hrdata),
        .fill_valid (fill_valid),
        .fill_idx   (fill_idx),
        .fill_data  (fill_data),
        .fill_crit  (fill_crit),
        .fill_done  (fill_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the words of the line in burst order.
    task automatic push_line(input logic [31:0] a);
        logic [31:0] base;
        int          crit;
        int          start;
        int          idx;
        addr_t       e;
        fill_t       f;
        base  = a & ~(32'(LW * 4) - 32'd1);
        crit  = int'((a >> 2) % 32'(LW));
        start = CWF ? crit : 0;
        for (int k = 0; k < LW; k++) begin
            idx     = (start + k) % LW;
            e.addr  = base + 32'(idx * 4);
            e.trans = (k == 0) ? 2'b10 : 2'b11;
            e.burst = EXP_BURST;
            exp_addr.push_back(e);
            f.idx   = idx[IDXW-1:0];
            f.data  = mem_word(e.addr);
            f.crit  = (idx == crit);
            f.done  = (k == LW - 1);
            exp_fill.push_back(f);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_htrans"},    htrans,     0);
        check({tag, "_haddr"},     haddr,      0);
        check({tag, "_hburst"},    hburst,     0);
        check({tag, "_miss_busy"}, miss_busy,  0);
        check({tag, "_fill_valid"}, fill_valid, 0);
        check({tag, "_fill_crit"}, fill_crit,  0);
        check({tag, "_fill_done"}, fill_done,  0);
        check({tag, "_fill_idx"},  fill_idx,   0);
        check({tag, "_fill_data"}, fill_data,  0);
    endtask

    // Waits for idle at a falling edge, then raises miss_req with the address.
    task automatic issue(input logic [31:0] a, output longint req_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while (miss_busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_issue", miss_busy, 0);
        miss_req  = 1'b1;
        miss_addr = a;
        push_line(a);
        req_cyc = cyc;
    endtask

    task automatic wait_nonseq(input bit drop, output longint c);
        bit seen;
        seen = 1'b0;
        c    = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (drop) miss_req = 1'b0;
            if (htrans == 2'b10) begin
                seen = 1'b1;
                c    = cyc;
            end
        end
        check("nonseq_seen", seen, 1);
    endtask

    task automatic wait_done(output longint c, output int pulses);
        bit seen;
        seen   = 1'b0;
        pulses = 0;
        c      = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (fill_valid) pulses++;
            if (fill_valid && fill_done) begin
                seen = 1'b1;
                c    = cyc;
            end
        end
        check("fill_done_seen", seen, 1);
    endtask

    // AHB slave: tracks the pending data phase and drives hready/hrdata just after each edge.
    initial begin
        logic        dph_valid;
        logic [31:0] dph_addr;
        dph_valid = 1'b0;
        dph_addr  = 32'h0;
        hready    = 1'b1;
        hrdata    = 32'h0;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                dph_valid = 1'b0;
            end else if (hready) begin
                dph_valid = (htrans != 2'b00);
                dph_addr  = haddr;
            end
            #1;
            case (hmode)
                0:       hready = 1'b1;
                1:       hready = ((($time - tog_base) % 50) >= 15);
                default: hready = ($urandom_range(0, 3) != 0);
            endcase
            hrdata = (dph_valid && hready) ? mem_word(dph_addr) : $urandom;
        end
    end

    // Monitor: pops the scoreboard on every accepted address phase and fill strobe.
    initial begin
        bit          prev_wait;
        logic [31:0] prev_addr;
        logic [1:0]  prev_trans;
        logic [2:0]  prev_burst;
        addr_t       ea;
        fill_t       ef;
        prev_wait  = 1'b0;
        prev_addr  = 32'h0;
        prev_trans = 2'b00;
        prev_burst = 3'b000;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_wait = 1'b0;
            end else begin
                if (prev_wait) begin
                    check("hold_while_wait", {haddr, htrans, hburst}, {prev_addr, prev_trans, prev_burst});
                end
                if (htrans != 2'b00) begin
                    check("busy_during_xfer", miss_busy, 1);
                    if (hready) begin
                        if (exp_addr.size() == 0) begin
                            check("addr_unexpected", htrans, 0);
                        end else begin
                            ea = exp_addr.pop_front();
                            check("haddr",  haddr,  ea.addr);
                            check("htrans", htrans, ea.trans);
                            check("hburst", hburst, ea.burst);
                            check("hwrite_hsize", {hwrite, hsize}, {1'b0, 3'b010});
                        end
                    end
                end
                prev_wait  = (htrans != 2'b00) && !hready;
                prev_addr  = haddr;
                prev_trans = htrans;
                prev_burst = hburst;
                if (fill_valid) begin
                    if (exp_fill.size() == 0) begin
                        check("fill_unexpected", fill_valid, 0);
                    end else begin
                        ef = exp_fill.pop_front();
                        check("fill_idx",  fill_idx,  ef.idx);
                        check("fill_data", fill_data, ef.data);
                        check("fill_crit", fill_crit, ef.crit);
                        check("fill_done", fill_done, ef.done);
                    end
                end else begin
                    check("strobes_quiet", {fill_crit, fill_done}, 0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached with %0d vectors applied", vectors);
        $fatal(1);
    end

    initial begin
        longint r, n, d, n2, d2;
        int     p, cnt;
        logic [31:0] a;
        rstn      = 1'b0;
        miss_req  = 1'b0;
        miss_addr = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        #2 rstn = 1'b1;

        // Zero wait states: order, latency, burst code.
        hmode = 0;
        issue(32'h0000_1238, r);
        wait_nonseq(1'b1, n);
        check("nonseq_latency", n - r, 1);
        wait_done(d, p);
        check("last_fill_latency", d - n, LW + 2);
        check("pulses_ready", p, LW);
        issue(32'h8000_0F04, r);
        wait_nonseq(1'b1, n);
        wait_done(d, p);
        check("pulses_ready2", p, LW);

        // hready 15 ns low / 35 ns high throughout.
        hmode    = 1;
        tog_base = $time;
        issue(32'h0000_1238, r);
        wait_nonseq(1'b1, n);
        wait_done(d, p);
        check("pulses_toggle", p, LW);
        issue(32'h0000_ABCC, r);
        wait_nonseq(1'b1, n);
        wait_done(d, p);
        check("pulses_toggle2", p, LW);

        // Reset after the second beat: partial line discarded.
        hmode = 0;
        issue(32'h0000_2224, r);
        wait_nonseq(1'b1, n);
        cnt = 0;
        for (int i = 0; i < 50 && cnt < 2; i++) begin
            @(negedge clk);
            if (fill_valid) cnt++;
        end
        check("beats_before_reset", cnt, 2);
        #2 rstn = 1'b0;
        #1 check_reset_vals("midburst_reset");
        exp_fill.delete();
        exp_addr.delete();
        @(negedge clk);
        #2 rstn = 1'b1;
        repeat (4) @(negedge clk);
        check("no_fill_after_reset", exp_fill.size(), 0);
        issue(32'h0000_1238, r);
        wait_nonseq(1'b1, n);
        wait_done(d, p);
        check("pulses_after_reset", p, LW);

        // miss_req held high: back-to-back refills, address change while busy ignored.
        issue(32'h0000_3334, r);
        wait_nonseq(1'b0, n);
        miss_addr = 32'h0000_5558;
        push_line(32'h0000_5558);
        wait_done(d, p);
        wait_nonseq(1'b0, n2);
        check("b2b_gap", n2 - d, 1);
        miss_req  = 1'b0;
        miss_addr = 32'hDEAD_BEE0;
        wait_done(d2, p);
        check("pulses_b2b", p, LW);
        repeat (3) @(negedge clk);
        check("no_third_refill", miss_busy, 0);

        // Randomised misses under random hready.
        hmode = 2;
        for (int it = 0; it < 24; it++) begin
            a = $urandom;
            issue(a, r);
            wait_nonseq(1'b1, n);
            miss_addr = $urandom;
            wait_done(d, p);
            check("pulses_random", p, LW);
        end

        hmode = 0;
        repeat (5) @(negedge clk);
        check("leftover_fills", exp_fill.size(), 0);
        check("leftover_addrs", exp_addr.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_refill_ctrl.md
AHB_REFILL_CTRL -- requirements
Module: ahb_refill_ctrl

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, words per cache line (legal: 4 or 8).
REQ-002 SHALL have port clk  input  1  system clock; all flops sample on the rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port miss_req  input  1  I-cache miss request, level, sampled only in IDLE.
REQ-005 SHALL have port miss_addr  input  32  missing word address, bits [1:0] ignored.
REQ-006 SHALL have port miss_busy  output  1  refill in progress; high in every state except IDLE.
REQ-007 SHALL have port haddr  output  32  AHB address.
REQ-008 SHALL have port htrans  output  2  AHB transfer type, TRANS_TYPES encoding.
REQ-009 SHALL have ports hwrite  output  1 (constant 0), hsize  output  3 (constant 3'b010), and hburst  output  3  burst type.
REQ-010 SHALL have ports hready  input  1  AHB ready, and hrdata  input  32  AHB read data.
REQ-011 SHALL have ports fill_valid  output  1  one-cycle strobe per captured beat; fill_idx  output  log2(LINE_WORDS)  word index in line; fill_data  output  32  captured word.
REQ-012 SHALL have ports fill_crit  output  1  high with fill_valid on the first beat (the missed word), and fill_done  output  1  high with fill_valid on the last beat.

Function
REQ-013 SHALL implement states IDLE, ADDR, BURST, DRAIN.
- IDLE -> ADDR on miss_req.
- ADDR -> BURST on hready.
- BURST -> DRAIN when the last address phase is accepted.
- DRAIN -> IDLE when the last data beat is captured.
REQ-014 SHALL latch miss_addr in IDLE when miss_req=1; miss_req seen while miss_busy=1 SHALL be ignored.
REQ-015 SHALL drive htrans=NONSEQ in ADDR, SEQ in BURST, and IDLE in IDLE and DRAIN.
REQ-016 SHALL compute beat k address as {line_base, (start_idx+k) mod LINE_WORDS, 2'b00}, where start_idx is the latched word index (wrap mode), with k advancing only on a cycle with htrans!=IDLE and hready=1.
REQ-017 SHALL hold haddr, htrans and hburst stable in any cycle with hready=0.
REQ-018 SHALL treat the data phase of beat k as the cycle after its address is accepted, and capture hrdata only when that data phase completes with hready=1.
REQ-019 SHALL register captures: fill_valid, fill_idx and fill_data appear one cycle after the capturing edge, and fill_valid stays low otherwise.
REQ-020 SHALL, with zero wait states, put NONSEQ on the bus 1 cycle after miss_req is sampled, issue LINE_WORDS consecutive address phases, and produce the last fill_valid/fill_done LINE_WORDS+2 cycles after the NONSEQ cycle.
REQ-021 SHALL tolerate hready=0 at any phase, including during NONSEQ, mid-burst and the final data phase, with no lost, duplicated or reordered beats.
REQ-022 SHALL allow a miss_req sampled in the cycle after fill_done to start a new refill with no dead cycle beyond IDLE.

Reset
REQ-023 SHALL, on rstn=0 at any time including mid-burst, asynchronously force state=IDLE, htrans=IDLE, haddr=0, hburst=SINGLE, miss_busy=0, fill_valid=0, fill_crit=0, fill_done=0, fill_idx=0 and fill_data=0, and discard the partial line.

Configuration
REQ-024 SHALL, when CRITICAL_WORD_FIRST_EN is defined, use wrap mode with hburst=WRAP4 (LINE_WORDS=4) or WRAP8 (LINE_WORDS=8) and start_idx = miss word index.
REQ-025 SHALL, when CRITICAL_WORD_FIRST_EN is not defined, force start_idx=0 and hburst=INCR4/INCR8, with fill_crit asserted on the beat whose index equals the missed word, not the first beat.

Structure
REQ-026 SHALL take TRANS_TYPES from interface_pkg and add to that package an HBURST_TYPES enum (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5) and a REFILL_STATE enum.
REQ-027 SHALL place beat address and index generation in one sub-module, refill_addr_gen, which is purely sequential beat counter plus combinational wrap logic.

Verification
REQ-028 Bench SHALL cover: miss_addr=0x0000_1238, hready=1, macro on -> haddr 0x1238, 0x123C, 0x1230, 0x1234; fill_idx 2,3,0,1; hburst=3'b010.
REQ-029 Bench SHALL cover: same miss, macro off -> haddr 0x1230..0x123C ascending; hburst=3'b011; fill_crit on the fill_idx=2 beat only.
REQ-030 Bench SHALL cover: hready toggled low 15 ns / high 35 ns throughout -> addresses held while low, exactly 4 fill_valid pulses, data matching hrdata at each accepted data phase.
REQ-031 Bench SHALL cover: rstn pulsed low after the 2nd beat -> outputs at reset values within the same cycle, no fill_done, and a later miss completes normally.
REQ-032 Bench SHALL cover: miss_req held high continuously -> back-to-back refills, second NONSEQ one cycle after the first fill_done; miss_req during a burst ignored.
